// File: rtl/dn_receiver.sv
// Download receiver: buffers loader bytes into shared-RAM writes, then starts the CPU.
// Define DN_RECEIVER_CHECKSUM_EN to build the running byte checksum.
module dn_receiver #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_sys,
  input  logic                        reset_n,
  input  logic                        dn_go,
  input  logic                        dn_wr,
  input  logic [15:0]                 dn_addr,
  input  logic [7:0]                  dn_data,
  input  logic [15:0]                 execute_addr,
  input  logic                        execute_enable,
  output logic                        ram_req,
  output logic [15:0]                 ram_addr,
  output logic [7:0]                  ram_dout,
  input  logic                        ram_ack,
  output logic                        cpu_hold,
  output logic                        cpu_start,
  output logic [15:0]                 cpu_start_addr,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic [7:0]                  checksum
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_START
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [15:0]     r_addr_mem [FIFO_DEPTH];
  logic [7:0]      r_data_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [LW-1:0]   r_count;
  logic            r_go_d;
  logic            r_pend;
  logic            r_ovf;
  logic [15:0]     r_start_addr;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push_req;
  logic w_push;
  logic w_drop;
  logic w_rise;
  logic w_pend;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == LW'(FIFO_DEPTH));
  assign w_pop      = !w_empty && ram_ack;
  assign w_push_req = dn_go && dn_wr;
  // A full FIFO still accepts when the head leaves in the same cycle
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;
  assign w_rise     = dn_go && !r_go_d;
  assign w_pend     = r_pend || execute_enable;

  always_ff @(posedge clk_sys) begin
    if (w_push) begin
      r_addr_mem[r_wptr] <= dn_addr;
      r_data_mem[r_wptr] <= dn_data;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (w_pop && !w_push)
        r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_go_d       <= 1'b0;
      r_pend       <= 1'b0;
      r_ovf        <= 1'b0;
      r_start_addr <= '0;
    end else begin
      r_state <= w_next;
      r_go_d  <= dn_go;
      if (execute_enable) begin
        r_pend       <= 1'b1;
        r_start_addr <= execute_addr;
      end else if (r_state == S_START) begin
        r_pend <= 1'b0;
      end
      if (w_drop)
        r_ovf <= 1'b1;
      else if (w_rise)
        r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (dn_go)
          w_next = S_LOAD;
        else if (w_pend && w_empty)
          w_next = S_START;
      end
      S_LOAD: begin
        if (!dn_go) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (dn_go)
          w_next = S_LOAD;
        else if (w_empty)
          w_next = w_pend ? S_START : S_IDLE;
      end
      S_START: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

`ifdef DN_RECEIVER_CHECKSUM_EN
  logic [7:0] r_sum;

  always_ff @(posedge clk_sys) begin
    if (!reset_n)
      r_sum <= '0;
    else if (w_rise)
      r_sum <= w_push ? dn_data : 8'h00;
    else if (w_push)
      r_sum <= r_sum + dn_data;
  end

  assign checksum = r_sum;
`else
  assign checksum = 8'h00;
`endif

  assign ram_req        = !w_empty;
  assign ram_addr       = w_empty ? 16'h0000 : r_addr_mem[r_rptr];
  assign ram_dout       = w_empty ? 8'h00 : r_data_mem[r_rptr];
  assign cpu_hold       = (r_state != S_IDLE);
  assign cpu_start      = (r_state == S_START);
  assign cpu_start_addr = r_start_addr;
  assign fifo_level     = r_count;
  assign overflow       = r_ovf;

endmodule

// File: tb/tb_dn_receiver.sv
// Directed self-checking bench for dn_receiver.
// Checksum expectations follow DN_RECEIVER_CHECKSUM_EN.
module tb_dn_receiver;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        dn_go;
  logic        dn_wr;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic [15:0] execute_addr;
  logic        execute_enable;
  logic        ram_req;
  logic [15:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_ack;
  logic        cpu_hold;
  logic        cpu_start;
  logic [15:0] cpu_start_addr;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic [7:0]  checksum;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_sys = ~clk_sys;

  dn_receiver #(.FIFO_DEPTH(4)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .dn_go          (dn_go),
    .dn_wr          (dn_wr),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .execute_addr   (execute_addr),
    .execute_enable (execute_enable),
    .ram_req        (ram_req),
    .ram_addr       (ram_addr),
    .ram_dout       (ram_dout),
    .ram_ack        (ram_ack),
    .cpu_hold       (cpu_hold),
    .cpu_start      (cpu_start),
    .cpu_start_addr (cpu_start_addr),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .checksum       (checksum)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle_out();
    dn_wr = 1'b0;
    dn_go = 1'b0;
    ram_ack = 1'b1;
    repeat (6) tick();
    ram_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    dn_go = 1'b0;
    dn_wr = 1'b0;
    dn_addr = 16'h0;
    dn_data = 8'h0;
    execute_addr = 16'h0;
    execute_enable = 1'b0;
    ram_ack = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({ram_req, cpu_hold, cpu_start, overflow} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags got %b exp 0000",
               {ram_req, cpu_hold, cpu_start, overflow});
    end
    n_tests++;
    if ({fifo_level, checksum, ram_addr, ram_dout, cpu_start_addr}
        !== 51'h0) begin
      n_fail++;
      $display("FAIL reset_vals lvl %0d sum %h a %h d %h s %h exp 0",
               fifo_level, checksum, ram_addr, ram_dout,
               cpu_start_addr);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [7:0] exp_sum;
    ram_ack = 1'b1;
    dn_go = 1'b1;
    dn_wr = 1'b1;
    dn_addr = 16'h0000;
    dn_data = 8'h3E;
    tick();
    dn_wr = 1'b0;
    n_tests++;
    if ({ram_req, ram_addr, ram_dout} !== {1'b1, 16'h0000, 8'h3E}) begin
      n_fail++;
      $display("FAIL single_req got %b %h %h exp 1 0000 3e",
               ram_req, ram_addr, ram_dout);
    end
    n_tests++;
    if (cpu_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL single_hold got %b exp 1", cpu_hold);
    end
`ifdef DN_RECEIVER_CHECKSUM_EN
    exp_sum = 8'h3E;
`else
    exp_sum = 8'h00;
`endif
    n_tests++;
    if (checksum !== exp_sum) begin
      n_fail++;
      $display("FAIL single_sum got %h exp %h", checksum, exp_sum);
    end
    tick();
    n_tests++;
    if ({ram_req, fifo_level} !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_done req %b lvl %0d exp 0 0",
               ram_req, fifo_level);
    end
    dn_go = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({cpu_hold, cpu_start} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_idle hold %b start %b exp 0 0",
               cpu_hold, cpu_start);
    end
    ram_ack = 1'b0;
  endtask

  task automatic test_idle_start();
    execute_addr = 16'h1234;
    execute_enable = 1'b1;
    tick();
    execute_enable = 1'b0;
    execute_addr = 16'h0;
    n_tests++;
    if ({cpu_start, cpu_hold, cpu_start_addr}
        !== {2'b11, 16'h1234}) begin
      n_fail++;
      $display("FAIL idle_start got %b %b %h exp 1 1 1234",
               cpu_start, cpu_hold, cpu_start_addr);
    end
    tick();
    n_tests++;
    if ({cpu_start, cpu_hold} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_start_end got %b %b exp 0 0",
               cpu_start, cpu_hold);
    end
    tick();
    n_tests++;
    if (cpu_start !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_start_once got %b exp 0", cpu_start);
    end
  endtask

  task automatic test_overflow();
    logic [7:0]  got_d [8];
    logic [15:0] got_a [8];
    int n;
    logic [7:0] exp_sum;
    ram_ack = 1'b0;
    dn_go = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dn_wr = 1'b1;
      dn_addr = 16'h0100 + 16'(i);
      dn_data = 8'(i + 1);
      tick();
    end
    dn_wr = 1'b0;
    n_tests++;
    if ({fifo_level, overflow, ram_req, ram_dout}
        !== {3'd4, 1'b1, 1'b1, 8'h01}) begin
      n_fail++;
      $display("FAIL ovf_state lvl %0d ovf %b req %b d %h exp 4 1 1 01",
               fifo_level, overflow, ram_req, ram_dout);
    end
`ifdef DN_RECEIVER_CHECKSUM_EN
    exp_sum = 8'h0A;
`else
    exp_sum = 8'h00;
`endif
    n_tests++;
    if (checksum !== exp_sum) begin
      n_fail++;
      $display("FAIL ovf_sum got %h exp %h", checksum, exp_sum);
    end
    ram_ack = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (ram_req) begin
        got_d[n] = ram_dout;
        got_a[n] = ram_addr;
        n++;
      end
      tick();
    end
    n_tests++;
    if (n !== 4) begin
      n_fail++;
      $display("FAIL ovf_count got %0d exp 4", n);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({got_a[i], got_d[i]} !== {16'h0100 + 16'(i), 8'(i + 1)}) begin
        n_fail++;
        $display("FAIL ovf_order[%0d] got %h/%h exp %h/%h", i,
                 got_a[i], got_d[i], 16'h0100 + 16'(i), 8'(i + 1));
      end
    end
    n_tests++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky got %b exp 1", overflow);
    end
    idle_out();
  endtask

  task automatic test_full_push_pop();
    logic [7:0] got_d [8];
    int n;
    logic [7:0] exp_sum;
    ram_ack = 1'b0;
    dn_go = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dn_wr = 1'b1;
      dn_addr = 16'h0200 + 16'(i);
      dn_data = 8'hA0 + 8'(i);
      tick();
    end
    n_tests++;
    if ({fifo_level, overflow} !== {3'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL full_fill lvl %0d ovf %b exp 4 0",
               fifo_level, overflow);
    end
    dn_addr = 16'h0204;
    dn_data = 8'hA4;
    ram_ack = 1'b1;
    tick();
    dn_wr = 1'b0;
    n_tests++;
    if ({fifo_level, overflow, ram_dout} !== {3'd4, 1'b0, 8'hA1}) begin
      n_fail++;
      $display("FAIL full_pushpop lvl %0d ovf %b d %h exp 4 0 a1",
               fifo_level, overflow, ram_dout);
    end
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (ram_req) begin
        got_d[n] = ram_dout;
        n++;
      end
      tick();
    end
    n_tests++;
    if (n !== 4) begin
      n_fail++;
      $display("FAIL full_count got %0d exp 4", n);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (got_d[i] !== 8'hA1 + 8'(i)) begin
        n_fail++;
        $display("FAIL full_order[%0d] got %h exp %h", i,
                 got_d[i], 8'hA1 + 8'(i));
      end
    end
`ifdef DN_RECEIVER_CHECKSUM_EN
    exp_sum = 8'h2A;
`else
    exp_sum = 8'h00;
`endif
    n_tests++;
    if (checksum !== exp_sum) begin
      n_fail++;
      $display("FAIL full_sum got %h exp %h", checksum, exp_sum);
    end
    idle_out();
  endtask

  task automatic test_checksum();
    logic [7:0] vals [3];
    logic [7:0] exp_sum;
    vals[0] = 8'hFF;
    vals[1] = 8'h02;
    vals[2] = 8'h10;
    ram_ack = 1'b1;
    dn_go = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dn_wr = 1'b1;
      dn_addr = 16'h0300 + 16'(i);
      dn_data = vals[i];
      tick();
    end
    dn_wr = 1'b0;
`ifdef DN_RECEIVER_CHECKSUM_EN
    exp_sum = 8'h11;
`else
    exp_sum = 8'h00;
`endif
    n_tests++;
    if (checksum !== exp_sum) begin
      n_fail++;
      $display("FAIL checksum got %h exp %h", checksum, exp_sum);
    end
    idle_out();
  endtask

  task automatic test_execute_stream();
    int errs;
    int early;
    int starts;
    ram_ack = 1'b1;
    dn_go = 1'b1;
    errs = 0;
    early = 0;
    for (int i = 0; i < 276; i++) begin
      dn_wr = 1'b1;
      dn_addr = 16'(i);
      dn_data = 8'(i);
      tick();
      if (!(ram_req && ram_addr == 16'(i) && ram_dout == 8'(i)))
        errs++;
      if (cpu_start) early++;
    end
    n_tests++;
    if (errs !== 0) begin
      n_fail++;
      $display("FAIL stream_order got %0d bad writes exp 0", errs);
    end
    dn_wr = 1'b0;
    dn_go = 1'b0;
    tick();
    if (cpu_start) early++;
    execute_addr = 16'h0000;
    execute_enable = 1'b1;
    tick();
    execute_enable = 1'b0;
    n_tests++;
    if (early !== 0) begin
      n_fail++;
      $display("FAIL exec_early got %0d pulses exp 0", early);
    end
    n_tests++;
    if ({cpu_start, cpu_hold, cpu_start_addr, ram_req}
        !== {2'b11, 16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL exec_start got %b %b %h req %b exp 1 1 0000 0",
               cpu_start, cpu_hold, cpu_start_addr, ram_req);
    end
    tick();
    n_tests++;
    if ({cpu_start, cpu_hold} !== 2'b00) begin
      n_fail++;
      $display("FAIL exec_idle got %b %b exp 0 0", cpu_start, cpu_hold);
    end
    starts = 0;
    for (int c = 0; c < 4; c++) begin
      if (cpu_start) starts++;
      tick();
    end
    n_tests++;
    if (starts !== 0) begin
      n_fail++;
      $display("FAIL exec_once got %0d extra pulses exp 0", starts);
    end
    ram_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    int writes;
    ram_ack = 1'b0;
    dn_go = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dn_wr = 1'b1;
      dn_addr = 16'h2000 + 16'(i);
      dn_data = 8'h50 + 8'(i);
      tick();
    end
    dn_wr = 1'b0;
    n_tests++;
    if ({ram_req, fifo_level, cpu_hold} !== {1'b1, 3'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL rmid_pre req %b lvl %0d hold %b exp 1 3 1",
               ram_req, fifo_level, cpu_hold);
    end
    reset_n = 1'b0;
    ram_ack = 1'b1;
    tick();
    n_tests++;
    if ({ram_req, fifo_level, cpu_hold} !== 5'b0) begin
      n_fail++;
      $display("FAIL rmid_post req %b lvl %0d hold %b exp 0 0 0",
               ram_req, fifo_level, cpu_hold);
    end
    reset_n = 1'b1;
    dn_go = 1'b0;
    writes = 0;
    for (int c = 0; c < 6; c++) begin
      if (ram_req) writes++;
      tick();
    end
    n_tests++;
    if (writes !== 0) begin
      n_fail++;
      $display("FAIL rmid_nowrite got %0d writes exp 0", writes);
    end
    n_tests++;
    if ({checksum, overflow} !== 9'h0) begin
      n_fail++;
      $display("FAIL rmid_clear sum %h ovf %b exp 00 0",
               checksum, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_idle_start();
    test_overflow();
    test_full_push_pop();
    test_checksum();
    test_execute_stream();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dn_receiver.md
DN_RECEIVER -- requirements
Module: dn_receiver

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, power-of-two byte buffer depth between download strobe and RAM port.
REQ-002 clk_sys  in  1  system clock (32 MHz); all logic on rising edge.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 dn_go  in  1  download window; high while the loader streams bytes.
REQ-005 dn_wr  in  1  one-cycle byte strobe; valid only while dn_go high.
REQ-006 dn_addr  in  16  target RAM address of the strobed byte.
REQ-007 dn_data  in  8  strobed byte.
REQ-008 execute_addr  in  16  CPU start address.
REQ-009 execute_enable  in  1  one-cycle pulse requesting CPU start after load.
REQ-010 ram_req  out  1  write request to shared RAM arbiter.
REQ-011 ram_addr  out  16  write address, stable while ram_req high.
REQ-012 ram_dout  out  8  write data, stable while ram_req high.
REQ-013 ram_ack  in  1  arbiter accepted the write this cycle.
REQ-014 cpu_hold  out  1  holds CPU in wait/reset while loading.
REQ-015 cpu_start  out  1  one-cycle pulse: CPU begins at cpu_start_addr.
REQ-016 cpu_start_addr  out  16  latched execute_addr.
REQ-017 fifo_level  out  log2(FIFO_DEPTH)+1  current buffered byte count.
REQ-018 overflow  out  1  sticky: a strobed byte was dropped.
REQ-019 checksum  out  8  mod-256 sum of accepted bytes (see Configuration).

Function
REQ-020 States: IDLE, LOAD, DRAIN, START; cpu_hold high in LOAD, DRAIN, START only.
REQ-021 IDLE->LOAD on the cycle dn_go samples high; a dn_go rising edge clears overflow and checksum.
REQ-022 LOAD->DRAIN when dn_go samples low; DRAIN->LOAD if dn_go rises again, FIFO contents preserved.
REQ-023 DRAIN->START when FIFO empty, ram_req low and execute pending; DRAIN->IDLE when empty with no execute pending.
REQ-024 START lasts exactly one cycle: cpu_start=1, then IDLE.
REQ-025 execute_enable in any state latches execute_addr into cpu_start_addr and sets execute pending; pending clears in START; in IDLE with empty FIFO, START follows next cycle.
REQ-026 dn_wr with dn_go high pushes {dn_addr,dn_data}; dn_wr with dn_go low is ignored.
REQ-027 Push into empty FIFO at cycle N gives ram_req=1 with that byte at cycle N+1.
REQ-028 ram_req, ram_addr, ram_dout held stable until ram_ack sampled high; entry popped that cycle; next request may assert the following cycle.
REQ-029 ram_ack while ram_req low is ignored.
REQ-030 Push when full with a pop in the same cycle is accepted; push when full without pop is dropped and sets overflow.
REQ-031 Writes reach RAM in strobe order; FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-032 reset_n low at a clock edge: state IDLE, FIFO emptied, pending cleared; ram_req, cpu_hold, cpu_start, overflow = 0; fifo_level, checksum, ram_addr, ram_dout, cpu_start_addr = 0.
REQ-033 Reset mid-transfer drops ram_req the next cycle regardless of ram_ack; buffered bytes are discarded.

Configuration
REQ-034 Macro DN_RECEIVER_CHECKSUM_EN: when defined, checksum adds each accepted (not dropped) byte mod 256, cleared per REQ-021/REQ-032.
REQ-035 Without DN_RECEIVER_CHECKSUM_EN, checksum is constant 0 and no adder is synthesized; all other behaviour identical.

Verification
REQ-036 dn_go=1, dn_wr at addr 0x0000 data 0x3E, ram_ack tied 1 -> ram_req at next cycle with 0x0000/0x3E, fifo_level back to 0 one cycle later.
REQ-037 ram_ack=0, six back-to-back strobes 0x01..0x06 -> first four buffered, overflow=1, fifo_level=4; release ack -> RAM sees 0x01..0x04 in order.
REQ-038 Load 276 bytes (0x0000..0x0113), dn_go falls, execute_enable with execute_addr=0x0000 one cycle later -> cpu_start single pulse only after last ack, cpu_start_addr=0x0000, cpu_hold falls same cycle state returns IDLE.
REQ-039 With macro defined, bytes 0xFF,0x02,0x10 -> checksum=0x11; without macro -> checksum=0x00.
REQ-040 Assert reset_n=0 while ram_req=1 and FIFO holds 3 bytes -> next cycle ram_req=0, fifo_level=0, cpu_hold=0, no RAM write issued afterward.
REQ-041 Full FIFO, ram_ack=1 and dn_wr same cycle -> byte accepted, overflow stays 0, fifo_level stays 4.
